gray_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer controller that sequences write/read pointers in Gray code and derives full/empty/occupancy from them. Drives the binary RAM addresses of an 2^AW-entry buffer and exports the (AW+1)-bit Gray pointers, so a later async-FIFO variant can cross them without change. Each pointer is a binary counter feeding the team's existing `bin_to_gray` converter.

---
 rtl/gray_ptr_pkg.sv | 20 ++
 rtl/bin_to_gray.sv | 11 +
 rtl/gray_ptr_cnt.sv | 41 ++++
 rtl/gray_ptr_ctrl.sv | 102 ++++++++++
 tb/tb_gray_ptr_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_ptr_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray pointer FIFO controller.
package gray_ptr_pkg;

  localparam int AW_DEFAULT = 3;
  localparam int PTR_MAX_W  = 9;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter shared across pointer logic.
module bin_to_gray #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_ptr_cnt.sv
// One FIFO pointer: binary counter mod 2^(AW+1) plus registered Gray image.
module gray_ptr_cnt #(
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic [AW:0]   o_bin_nxt,
  output logic [AW:0]   o_gray,
  output logic [AW:0]   o_gray_nxt
);

  logic [AW:0] bin_q;
  logic [AW:0] bin_nxt;
  logic [AW:0] gray_nxt;
  logic [AW:0] gray_q;

  assign bin_nxt = bin_q + {{AW{1'b0}}, i_inc};

  bin_to_gray #(.W(AW + 1)) u_b2g (
    .i_bin  (bin_nxt),
    .o_gray (gray_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
    end
  end

  assign o_addr     = bin_q[AW-1:0];
  assign o_bin_nxt  = bin_nxt;
  assign o_gray     = gray_q;
  assign o_gray_nxt = gray_nxt;

endmodule

// File: rtl/gray_ptr_ctrl.sv
// Single-clock FIFO pointer controller with Gray pointers, registered flags and occupancy.
// Optional sticky overflow/underflow flops are built when GRAY_PTR_ERR_EN is defined.
module gray_ptr_ctrl
  import gray_ptr_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic          i_rd_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW:0]   o_wr_ptr_gray,
  output logic [AW:0]   o_rd_ptr_gray,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_ovf,
  output logic          o_udf
);

  logic        wr_acc;
  logic        rd_acc;
  logic [AW:0] wr_bin_nxt;
  logic [AW:0] rd_bin_nxt;
  logic [AW:0] wr_gray_nxt;
  logic [AW:0] rd_gray_nxt;
  logic        full_nxt;
  logic        empty_nxt;
  logic [AW:0] count_nxt;
  logic        full_q;
  logic        empty_q;
  logic [AW:0] count_q;

  // Accept decisions use only registered flags, so no input reaches an output combinationally.
  assign wr_acc = i_wr_en & ~full_q;
  assign rd_acc = i_rd_en & ~empty_q;

  gray_ptr_cnt #(.AW(AW)) u_wr_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (wr_acc),
    .o_addr     (o_wr_addr),
    .o_bin_nxt  (wr_bin_nxt),
    .o_gray     (o_wr_ptr_gray),
    .o_gray_nxt (wr_gray_nxt)
  );

  gray_ptr_cnt #(.AW(AW)) u_rd_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (rd_acc),
    .o_addr     (o_rd_addr),
    .o_bin_nxt  (rd_bin_nxt),
    .o_gray     (o_rd_ptr_gray),
    .o_gray_nxt (rd_gray_nxt)
  );

  // Full in Gray space: top two bits inverted, remainder equal.
  assign empty_nxt = (wr_gray_nxt == rd_gray_nxt);
  assign full_nxt  = (wr_gray_nxt == {~rd_gray_nxt[AW:AW-1], rd_gray_nxt[AW-2:0]});
  assign count_nxt = wr_bin_nxt - rd_bin_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      count_q <= '0;
    end else begin
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
      count_q <= count_nxt;
    end
  end

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

`ifdef GRAY_PTR_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (i_wr_en & full_q);
      udf_q <= udf_q | (i_rd_en & empty_q);
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`else
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Self-checking bench for gray_ptr_ctrl (AW=3) against an occupancy/pointer-count reference model.
module tb_gray_ptr_ctrl;
  import gray_ptr_pkg::*;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;
`ifdef GRAY_PTR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr_en = 1'b0;
  logic          i_rd_en = 1'b0;
  logic [AW-1:0] o_wr_addr;
  logic [AW-1:0] o_rd_addr;
  logic [AW:0]   o_wr_ptr_gray;
  logic [AW:0]   o_rd_ptr_gray;
  logic          o_full;
  logic          o_empty;
  logic [AW:0]   o_count;
  logic          o_ovf;
  logic          o_udf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: occupancy and pointer positions as plain integers.
  int m_count, m_wr, m_rd;
  bit m_ovf, m_udf, m_wacc, m_racc;
  logic [AW:0] prev_wg, prev_rg;

  gray_ptr_ctrl #(.AW(AW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (i_wr_en),
    .i_rd_en       (i_rd_en),
    .o_wr_addr     (o_wr_addr),
    .o_rd_addr     (o_rd_addr),
    .o_wr_ptr_gray (o_wr_ptr_gray),
    .o_rd_ptr_gray (o_rd_ptr_gray),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_ovf         (o_ovf),
    .o_udf         (o_udf)
  );

  always #5 i_clk = ~i_clk;

  function automatic int g2b(input logic [AW:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = gray2bin({{(PTR_MAX_W-AW-1){1'b0}}, g});
    return int'(b);
  endfunction

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_rd = 0;
    m_ovf = 0; m_udf = 0; m_wacc = 0; m_racc = 0;
  endtask

  // Drive one cycle (called 1 time unit after an edge) and advance the model.
  task automatic step(input bit wr, input bit rd);
    i_wr_en = wr;
    i_rd_en = rd;
    prev_wg = o_wr_ptr_gray;
    prev_rg = o_rd_ptr_gray;
    @(posedge i_clk);
    m_wacc = wr && (m_count < DEPTH);
    m_racc = rd && (m_count > 0);
    if (wr && m_count == DEPTH) m_ovf = 1;
    if (rd && m_count == 0) m_udf = 1;
    if (m_wacc) m_wr = (m_wr + 1) % PMOD;
    if (m_racc) m_rd = (m_rd + 1) % PMOD;
    m_count = m_count + int'(m_wacc) - int'(m_racc);
    #1;
    i_wr_en = 0;
    i_rd_en = 0;
  endtask

  task automatic do_reset();
    i_rst = 1;
    @(posedge i_clk);
    #1;
    i_rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== '0) begin
      n_errors++;
      $display("FAIL reset_flags: empty=%b full=%b count=%0d, required 1 0 0", o_empty, o_full, o_count);
    end
    n_checks++;
    if (o_wr_ptr_gray !== 4'b0000 || o_rd_ptr_gray !== 4'b0000 || o_wr_addr !== '0 || o_rd_addr !== '0) begin
      n_errors++;
      $display("FAIL reset_ptrs: wg=%b rg=%b wa=%0d ra=%0d, required all zero", o_wr_ptr_gray, o_rd_ptr_gray, o_wr_addr, o_rd_addr);
    end
    n_checks++;
    if (o_ovf !== 1'b0 || o_udf !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err: ovf=%b udf=%b, required 0 0", o_ovf, o_udf);
    end
    step(0, 0);
    n_checks++;
    if (o_empty !== 1'b1 || o_count !== '0) begin
      n_errors++;
      $display("FAIL idle: empty=%b count=%0d, required 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0);
      n_checks++;
      if (o_count !== (AW+1)'(i) || o_wr_addr !== AW'(i)) begin
        n_errors++;
        $display("FAIL fill_count[%0d]: count=%0d waddr=%0d, required %0d %0d", i, o_count, o_wr_addr, i, i % DEPTH);
      end
    end
    n_checks++;
    if (o_full !== 1'b1 || o_empty !== 1'b0 || o_wr_ptr_gray !== 4'b1100) begin
      n_errors++;
      $display("FAIL fill_full: full=%b empty=%b wg=%b, required 1 0 1100", o_full, o_empty, o_wr_ptr_gray);
    end
    step(1, 0);
    n_checks++;
    if (o_wr_ptr_gray !== 4'b1100 || o_count !== 4'd8 || o_full !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow_reject: wg=%b count=%0d full=%b, required 1100 8 1", o_wr_ptr_gray, o_count, o_full);
    end
    n_checks++;
    if (o_ovf !== ERR_EN) begin
      n_errors++;
      $display("FAIL ovf_flag: ovf=%b, required %b", o_ovf, ERR_EN);
    end
  endtask

  task automatic test_full_wr_rd();
    step(1, 1);
    n_checks++;
    if (o_full !== 1'b0 || o_count !== 4'd7 || o_rd_addr !== 3'd1 || o_wr_ptr_gray !== 4'b1100) begin
      n_errors++;
      $display("FAIL full_wr_rd: full=%b count=%0d raddr=%0d wg=%b, required 0 7 1 1100", o_full, o_count, o_rd_addr, o_wr_ptr_gray);
    end
  endtask

  task automatic test_empty_wr_rd();
    for (int i = 0; i < 7; i++) step(0, 1);
    n_checks++;
    if (o_empty !== 1'b1 || o_count !== '0) begin
      n_errors++;
      $display("FAIL drain: empty=%b count=%0d, required 1 0", o_empty, o_count);
    end
    step(1, 1);
    n_checks++;
    if (o_empty !== 1'b0 || o_count !== 4'd1 || o_rd_addr !== 3'd0) begin
      n_errors++;
      $display("FAIL empty_wr_rd: empty=%b count=%0d raddr=%0d, required 0 1 0", o_empty, o_count, o_rd_addr);
    end
    step(0, 1);
    step(0, 1);
    n_checks++;
    if (o_udf !== ERR_EN || o_empty !== 1'b1 || g2b(o_rd_ptr_gray) != m_rd) begin
      n_errors++;
      $display("FAIL underflow: udf=%b empty=%b rptr=%0d, required %b 1 %0d", o_udf, o_empty, g2b(o_rd_ptr_gray), ERR_EN, m_rd);
    end
  endtask

  task automatic test_steady();
    int wraps;
    wraps = 0;
    for (int i = 0; i < 4; i++) step(1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 1);
      if (m_wr == 0) wraps++;
      n_checks++;
      if (o_count !== 4'd4 || $countones(prev_wg ^ o_wr_ptr_gray) != 1 || $countones(prev_rg ^ o_rd_ptr_gray) != 1) begin
        n_errors++;
        $display("FAIL steady[%0d]: count=%0d wg %b->%b rg %b->%b, required count 4 and one-bit steps", i, o_count, prev_wg, o_wr_ptr_gray, prev_rg, o_rd_ptr_gray);
      end
    end
    n_checks++;
    if (wraps < 2 || g2b(o_wr_ptr_gray) != m_wr || g2b(o_rd_ptr_gray) != m_rd) begin
      n_errors++;
      $display("FAIL steady_wrap: wraps=%0d wptr=%0d rptr=%0d, required >=2 %0d %0d", wraps, g2b(o_wr_ptr_gray), g2b(o_rd_ptr_gray), m_wr, m_rd);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1, 0);
    #2;
    i_rst = 1;
    #1;
    n_checks++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_wr_ptr_gray !== '0 ||
        o_rd_ptr_gray !== '0 || o_wr_addr !== '0 || o_rd_addr !== '0 || o_ovf !== 1'b0 || o_udf !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: count=%0d empty=%b full=%b wg=%b rg=%b ovf=%b udf=%b, required reset values",
               o_count, o_empty, o_full, o_wr_ptr_gray, o_rd_ptr_gray, o_ovf, o_udf);
    end
    @(posedge i_clk);
    #1;
    i_rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      // Vary the write/read bias in phases so both flags are hit often.
      int wp, rp;
      wp = ((i / 500) % 3 == 0) ? 80 : (((i / 500) % 3 == 1) ? 30 : 50);
      rp = 100 - wp;
      step($urandom_range(99) < wp, $urandom_range(99) < rp);
      n_checks++;
      if (o_count !== (AW+1)'(m_count) || o_full !== (m_count == DEPTH) || o_empty !== (m_count == 0) ||
          g2b(o_wr_ptr_gray) != m_wr || g2b(o_rd_ptr_gray) != m_rd ||
          o_wr_addr !== AW'(m_wr % DEPTH) || o_rd_addr !== AW'(m_rd % DEPTH) ||
          $countones(prev_wg ^ o_wr_ptr_gray) != int'(m_wacc) ||
          $countones(prev_rg ^ o_rd_ptr_gray) != int'(m_racc) ||
          o_ovf !== (ERR_EN & m_ovf) || o_udf !== (ERR_EN & m_udf)) begin
        n_errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: count=%0d full=%b empty=%b wptr=%0d rptr=%0d ovf=%b udf=%b, required %0d %b %b %0d %0d %b %b",
                   i, o_count, o_full, o_empty, g2b(o_wr_ptr_gray), g2b(o_rd_ptr_gray), o_ovf, o_udf,
                   m_count, m_count == DEPTH, m_count == 0, m_wr, m_rd, ERR_EN & m_ovf, ERR_EN & m_udf);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_fill();
    test_full_wr_rd();
    test_empty_wr_rd();
    test_steady();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
